// File: rtl/sn76489_psg_if.sv
// Register-write bus and audio output of the PSG; the system side is the master.
interface sn76489_psg_if;
  logic       clk_en;
  logic       nWE;
  logic [7:0] DATA;
  logic       PWM;

  modport master (output clk_en, output nWE, output DATA, input PWM);
  modport slave  (input clk_en, input nWE, input DATA, output PWM);
endinterface

// File: rtl/sn76489_psg.sv
// SN76489-style PSG: three tone and one LFSR noise channel, mixed and output as 1-bit PWM.
// PWM is registered one clk after the compare; writes are fire-and-forget, no backpressure.
module sn76489_psg (
  input  logic         clk,
  input  logic         RESET,
  sn76489_psg_if.slave bus
);

  logic            r_nwe_prev;
  logic [2:0]      r_latch;
  logic [2:0][9:0] r_tone;
  logic [2:0]      r_noise;
  logic [3:0][3:0] r_att;
  logic [2:0]      r_presc;
  logic [2:0][9:0] r_cnt;
  logic [2:0]      r_out;
  logic [6:0]      r_ncnt;
  logic            r_nclk;
  logic [14:0]     r_lfsr;
  logic [9:0]      r_pcnt;
  logic [9:0]      r_psamp;
  logic            r_pwm;

  logic       w_wr;
  logic       w_tick;
  logic       w_noise_wr;
  logic [6:0] w_nrel;
  logic [6:0] w_ncnt_nxt;
  logic       w_nclk_nxt;
  logic       w_shift;
  logic       w_fb;
  logic [3:0] w_chan;
  logic [9:0] w_sample;

  function automatic logic [7:0] f_level(input logic [3:0] a);
    case (a)
      4'd0:    return 8'd255;
      4'd1:    return 8'd203;
      4'd2:    return 8'd161;
      4'd3:    return 8'd128;
      4'd4:    return 8'd102;
      4'd5:    return 8'd81;
      4'd6:    return 8'd64;
      4'd7:    return 8'd51;
      4'd8:    return 8'd40;
      4'd9:    return 8'd32;
      4'd10:   return 8'd26;
      4'd11:   return 8'd20;
      4'd12:   return 8'd16;
      4'd13:   return 8'd13;
      4'd14:   return 8'd10;
      default: return 8'd0;
    endcase
  endfunction

  // One write per low period of nWE, judged only on clk_en samples.
  assign w_wr       = bus.clk_en & ~bus.nWE & r_nwe_prev;
  assign w_tick     = bus.clk_en & (r_presc == 3'd7);
  assign w_noise_wr = w_wr & (bus.DATA[7] ? (bus.DATA[6:4] == 3'd6) : (r_latch == 3'd6));

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_nwe_prev <= 1'b1;
      r_latch    <= '0;
      r_tone     <= '0;
      r_noise    <= '0;
      r_att      <= {4{4'hF}};
    end else begin
      if (bus.clk_en) r_nwe_prev <= bus.nWE;
      if (w_wr) begin
        if (bus.DATA[7]) begin
          r_latch <= bus.DATA[6:4];
          case (bus.DATA[6:4])
            3'd0:    r_tone[0][3:0] <= bus.DATA[3:0];
            3'd1:    r_att[0]       <= bus.DATA[3:0];
            3'd2:    r_tone[1][3:0] <= bus.DATA[3:0];
            3'd3:    r_att[1]       <= bus.DATA[3:0];
            3'd4:    r_tone[2][3:0] <= bus.DATA[3:0];
            3'd5:    r_att[2]       <= bus.DATA[3:0];
            3'd6:    r_noise        <= bus.DATA[2:0];
            default: r_att[3]       <= bus.DATA[3:0];
          endcase
        end else begin
          case (r_latch)
            3'd0:    r_tone[0][9:4] <= bus.DATA[5:0];
            3'd1:    r_att[0]       <= bus.DATA[3:0];
            3'd2:    r_tone[1][9:4] <= bus.DATA[5:0];
            3'd3:    r_att[1]       <= bus.DATA[3:0];
            3'd4:    r_tone[2][9:4] <= bus.DATA[5:0];
            3'd5:    r_att[2]       <= bus.DATA[3:0];
            3'd6:    r_noise        <= bus.DATA[2:0];
            default: r_att[3]       <= bus.DATA[3:0];
          endcase
        end
      end
    end
  end

  // Reload reads the pre-write period, so a same-cycle tone write lands on the next reload.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
    end else if (bus.clk_en) begin
      r_presc <= r_presc + 3'd1;
      if (w_tick) begin
        for (int n = 0; n < 3; n++) begin
          if (r_cnt[n] <= 10'd1) begin
            r_cnt[n] <= r_tone[n];
            r_out[n] <= ~r_out[n];
          end else begin
            r_cnt[n] <= r_cnt[n] - 10'd1;
          end
        end
      end
    end
  end

  assign w_nrel = (r_noise[1:0] == 2'b00) ? 7'd16 :
                  (r_noise[1:0] == 2'b01) ? 7'd32 : 7'd64;

  always_comb begin
    w_nclk_nxt = r_nclk;
    w_ncnt_nxt = r_ncnt;
    if (r_noise[1:0] == 2'b11) begin
      w_nclk_nxt = r_out[2];
    end else if (w_tick) begin
      if (r_ncnt <= 7'd1) begin
        w_ncnt_nxt = w_nrel;
        w_nclk_nxt = ~r_nclk;
      end else begin
        w_ncnt_nxt = r_ncnt - 7'd1;
      end
    end
  end

  assign w_shift = bus.clk_en & ~r_nclk & w_nclk_nxt;
  assign w_fb    = r_noise[2] ? (r_lfsr[0] ^ r_lfsr[1]) : r_lfsr[0];

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_ncnt <= '0;
      r_nclk <= 1'b0;
      r_lfsr <= 15'h4000;
    end else begin
      if (bus.clk_en) begin
        r_ncnt <= w_ncnt_nxt;
        r_nclk <= w_nclk_nxt;
      end
      if (w_noise_wr)   r_lfsr <= 15'h4000;
      else if (w_shift) r_lfsr <= {w_fb, r_lfsr[14:1]};
    end
  end

  // A period of 0 or 1 reads as constant high regardless of the toggle flop.
  always_comb begin
    w_chan = '0;
    for (int n = 0; n < 3; n++) w_chan[n] = r_out[n] | (r_tone[n] <= 10'd1);
    w_chan[3] = r_lfsr[0];
  end

  always_comb begin
    w_sample = '0;
    for (int n = 0; n < 4; n++)
      if (w_chan[n]) w_sample = w_sample + {2'b00, f_level(r_att[n])};
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_pcnt  <= '0;
      r_psamp <= '0;
      r_pwm   <= 1'b0;
    end else begin
      r_pcnt <= r_pcnt + 10'd1;
      if (r_pcnt == 10'h3FF) r_psamp <= w_sample;
      r_pwm <= (r_pcnt < r_psamp);
    end
  end

  assign bus.PWM = r_pwm;

endmodule
